// File: rtl/gaussian_blur_pipe_if.sv
// rtl/gaussian_blur_pipe_if.sv - window-in / pixel-out handshake bundle for gaussian_blur_pipe
interface gaussian_blur_pipe_if #(
  parameter int WIDTH = 8
);
  logic [3*WIDTH-1:0] r0_data_in;
  logic [3*WIDTH-1:0] r1_data_in;
  logic [3*WIDTH-1:0] r2_data_in;
  logic [1:0]         mode_in;
  logic               data_valid_in;
  logic               ready_out;
  logic               data_ready_in;
  logic [WIDTH-1:0]   data_out;
  logic               data_valid_out;
  logic               error_out;
  logic               busy_out;

  modport master (
    output r0_data_in, r1_data_in, r2_data_in, mode_in, data_valid_in, data_ready_in,
    input  ready_out, data_out, data_valid_out, error_out, busy_out
  );

  modport slave (
    input  r0_data_in, r1_data_in, r2_data_in, mode_in, data_valid_in, data_ready_in,
    output ready_out, data_out, data_valid_out, error_out, busy_out
  );
endinterface

// File: rtl/gaussian_blur_pipe.sv
// rtl/gaussian_blur_pipe.sv - 3-stage separable 3x3 blur with per-window kernel and backpressure
module gaussian_blur_pipe #(
  parameter int WIDTH = 8,
  parameter int ROUND = 1
) (
  input logic               clk_in,
  input logic               rst_in,
  gaussian_blur_pipe_if.slave bus
);
  localparam int HW = WIDTH + 3;
  localparam int VW = WIDTH + 6;
  localparam int NW = WIDTH + 7;

  // mode[1] selects passthrough (modes 2 and 3), mode[0] selects the [1 6 1] kernel
  function automatic logic [HW-1:0] hpass(input logic [3*WIDTH-1:0] row, input logic six);
    logic [HW-1:0] a, b, c;
    a = HW'(row[3*WIDTH-1:2*WIDTH]);
    b = HW'(row[2*WIDTH-1:WIDTH]);
    c = HW'(row[WIDTH-1:0]);
    return six ? a + (b << 2) + (b << 1) + c : a + (b << 1) + c;
  endfunction

  function automatic logic [VW-1:0] vpass(input logic [HW-1:0] h0, input logic [HW-1:0] h1,
                                          input logic [HW-1:0] h2, input logic six);
    logic [VW-1:0] a, b, c;
    a = VW'(h0);
    b = VW'(h1);
    c = VW'(h2);
    return six ? a + (b << 2) + (b << 1) + c : a + (b << 1) + c;
  endfunction

  logic          s1_valid_q, s2_valid_q, s3_valid_q;
  logic [1:0]    s1_mode_q, s2_mode_q;
  logic [HW-1:0] h0_q, h1_q, h2_q;
  logic [VW-1:0] v_q;
  logic [WIDTH-1:0] data_q;
  logic          error_q, busy_q;

  logic          stall, ready, accept;
  logic [NW-1:0] rnd_add, shifted;
  logic [WIDTH-1:0] norm_d;

  assign stall  = s3_valid_q && !bus.data_ready_in;
  assign ready  = !stall;
  assign accept = bus.data_valid_in && ready;

  always_comb begin
    rnd_add = '0;
    shifted = NW'(v_q);
    if (!s2_mode_q[1]) begin
      if (ROUND != 0) rnd_add = s2_mode_q[0] ? NW'(32) : NW'(8);
      shifted = s2_mode_q[0] ? (NW'(v_q) + rnd_add) >> 6 : (NW'(v_q) + rnd_add) >> 4;
    end
    norm_d = (shifted > NW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      data_q     <= '0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (bus.data_valid_in && !ready) error_q <= 1'b1;
      if (!stall) begin
        s1_valid_q <= accept;
        s1_mode_q  <= bus.mode_in;
        h0_q       <= hpass(bus.r0_data_in, bus.mode_in[0]);
        h1_q       <= bus.mode_in[1] ? HW'(bus.r1_data_in[2*WIDTH-1:WIDTH])
                                     : hpass(bus.r1_data_in, bus.mode_in[0]);
        h2_q       <= hpass(bus.r2_data_in, bus.mode_in[0]);

        s2_valid_q <= s1_valid_q;
        s2_mode_q  <= s1_mode_q;
        v_q        <= s1_mode_q[1] ? VW'(h1_q) : vpass(h0_q, h1_q, h2_q, s1_mode_q[0]);

        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) data_q <= norm_d;

        busy_q     <= accept | s1_valid_q | s2_valid_q;
      end
    end
  end

  assign bus.ready_out      = ready;
  assign bus.data_out       = data_q;
  assign bus.data_valid_out = s3_valid_q;
  assign bus.error_out      = error_q;
  assign bus.busy_out       = busy_q;
endmodule

// File: tb/tb_gaussian_blur_pipe.sv
// tb/tb_gaussian_blur_pipe.sv - scoreboard bench for gaussian_blur_pipe, ROUND=1 and ROUND=0 side by side
module tb_gaussian_blur_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] r0_d, r1_d, r2_d;
  logic [1:0]  mode_d;
  logic        vin, drdy;

  gaussian_blur_pipe_if #(.WIDTH(8)) ifa ();
  gaussian_blur_pipe_if #(.WIDTH(8)) ifb ();

  assign ifa.r0_data_in = r0_d;   assign ifb.r0_data_in = r0_d;
  assign ifa.r1_data_in = r1_d;   assign ifb.r1_data_in = r1_d;
  assign ifa.r2_data_in = r2_d;   assign ifb.r2_data_in = r2_d;
  assign ifa.mode_in = mode_d;    assign ifb.mode_in = mode_d;
  assign ifa.data_valid_in = vin; assign ifb.data_valid_in = vin;
  assign ifa.data_ready_in = drdy; assign ifb.data_ready_in = drdy;

  gaussian_blur_pipe #(.WIDTH(8), .ROUND(1)) dut_a (.clk_in(clk), .rst_in(rst), .bus(ifa));
  gaussian_blur_pipe #(.WIDTH(8), .ROUND(0)) dut_b (.clk_in(clk), .rst_in(rst), .bus(ifb));

  typedef struct {
    logic [23:0] r0, r1, r2;
    logic [1:0]  mode;
    int          ea, eb;
  } win_t;

  win_t pend[$];
  int   qa[$], qb[$];
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, out_cnt = 0, first_out_cyc = -1, first_acc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: full 2D kernel as outer product of [1 k 1], divided by its total weight
  function automatic int ref_blur(input logic [23:0] r0, input logic [23:0] r1,
                                  input logic [23:0] r2, input logic [1:0] mode, input int rnd);
    logic [23:0] rows[3];
    int p[3][3];
    int w[3];
    int s, div;
    rows[0] = r0; rows[1] = r1; rows[2] = r2;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = int'(rows[i][23-8*j -: 8]);
    if (mode >= 2) return p[1][1];
    w[0] = 1; w[2] = 1; w[1] = (mode == 0) ? 2 : 6;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += w[i] * w[j] * p[i][j];
    div = (w[0] + w[1] + w[2]) * (w[0] + w[1] + w[2]);
    if (rnd != 0) s += div / 2;
    s = s / div;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic add_dir(input logic [23:0] r0, input logic [23:0] r1, input logic [23:0] r2,
                         input logic [1:0] mode, input int ea, input int eb);
    win_t w;
    w.r0 = r0; w.r1 = r1; w.r2 = r2; w.mode = mode; w.ea = ea; w.eb = eb;
    pend.push_back(w);
  endtask

  task automatic add_rand(input logic [1:0] mode);
    win_t w;
    w.r0 = 24'($urandom); w.r1 = 24'($urandom); w.r2 = 24'($urandom); w.mode = mode;
    w.ea = ref_blur(w.r0, w.r1, w.r2, mode, 1);
    w.eb = ref_blur(w.r0, w.r1, w.r2, mode, 0);
    pend.push_back(w);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.data_valid_out && drdy) begin
        if (qa.size() == 0) check("unexpected_out_r1", int'(ifa.data_out), -1);
        else check("out_round1", int'(ifa.data_out), qa.pop_front());
        if (out_cnt == 0) first_out_cyc = cyc;
        out_cnt++;
      end
      if (ifb.data_valid_out && drdy) begin
        if (qb.size() == 0) check("unexpected_out_r0", int'(ifb.data_out), -1);
        else check("out_round0", int'(ifb.data_out), qb.pop_front());
      end
    end
  end

  // One loop iteration per cycle; inputs change 1-2 time units after posedge
  task automatic stream(input int stall_start, input int stall_len, input int inj, input int ncyc);
    logic [7:0] held;
    held = '0;
    for (int c = 0; c < ncyc; c++) begin
      drdy = !(c >= stall_start && c < stall_start + stall_len);
      #1;
      if (c == inj) begin
        r0_d = 24'($urandom); r1_d = 24'($urandom); r2_d = 24'($urandom);
        mode_d = 2'd0; vin = 1'b1;
      end else if (pend.size() > 0 && ifa.ready_out) begin
        win_t w;
        w = pend.pop_front();
        r0_d = w.r0; r1_d = w.r1; r2_d = w.r2; mode_d = w.mode; vin = 1'b1;
        qa.push_back(w.ea);
        qb.push_back(w.eb);
        if (first_acc < 0) first_acc = cyc;
      end else begin
        vin = 1'b0;
      end
      @(negedge clk);
      if (c >= stall_start && c < stall_start + stall_len) begin
        check("stall_ready_low", int'(ifa.ready_out), 0);
        if (c == stall_start) held = ifa.data_out;
        else check("stall_data_held", int'(ifa.data_out), int'(held));
      end
      if (inj >= 0 && c == inj + 1) check("error_rise", int'(ifa.error_out), 1);
      @(posedge clk); #1;
    end
    vin = 1'b0;
    drdy = 1'b1;
  endtask

  task automatic drain();
    vin = 1'b0;
    drdy = 1'b1;
    for (int i = 0; i < 60 && (qa.size() > 0 || qb.size() > 0); i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("drain_empty", qa.size() + qb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    rst = 1'b1; vin = 1'b0; drdy = 1'b1;
    r0_d = '0; r1_d = '0; r2_d = '0; mode_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", int'(ifa.data_valid_out), 0);
    check("rst_busy", int'(ifa.busy_out), 0);
    check("rst_error", int'(ifa.error_out), 0);
    check("rst_ready", int'(ifa.ready_out), 1);
    check("rst_data_out", int'(ifa.data_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    add_dir(24'h000000, 24'h000000, 24'h000000, 2'd0, 0, 0);
    add_dir(24'h010101, 24'h010101, 24'h010101, 2'd0, 1, 1);
    add_dir(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 2'd0, 255, 255);
    out_cnt = 0; first_acc = -1; first_out_cyc = -1;
    stream(1000, 0, -1, 3);
    drain();
    check("first_latency", first_out_cyc - first_acc, 3);

    add_dir(24'h010203, 24'h040506, 24'h070809, 2'd0, 5, 5);
    add_dir(24'h010203, 24'h040506, 24'h070809, 2'd1, 5, 5);
    add_dir(24'h010203, 24'h040506, 24'h070809, 2'd2, 5, 5);
    add_dir(24'h000000, 24'h00FF00, 24'h000000, 2'd0, 64, 63);
    add_dir(24'h000000, 24'h00FF00, 24'h000000, 2'd1, 143, 143);
    add_dir(24'hFFFFFF, 24'h407A33, 24'h112233, 2'd3, 122, 122);
    stream(1000, 0, -1, 8);
    drain();

    for (int i = 0; i < 6; i++) add_rand(2'(i % 2));
    stream(4, 4, -1, 14);
    drain();
    check("no_error_after_stall", int'(ifa.error_out), 0);

    for (int i = 0; i < 3; i++) add_rand(2'(i % 2));
    stream(4, 4, 5, 12);
    drain();
    check("error_sticky", int'(ifa.error_out), 1);

    for (int i = 0; i < 3; i++) add_rand(2'd0);
    stream(1000, 0, -1, 3);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid_out", int'(ifa.data_valid_out), 0);
    check("midrst_busy", int'(ifa.busy_out), 0);
    check("midrst_error", int'(ifa.error_out), 0);
    repeat (10) @(posedge clk);
    #1;

    sent = 0;
    for (int c = 0; c < 2000 && sent < 200; c++) begin
      drdy = ($urandom_range(0, 3) != 0);
      #1;
      if (ifa.ready_out && $urandom_range(0, 4) != 0) begin
        win_t w;
        add_rand(2'($urandom_range(0, 3)));
        w = pend.pop_front();
        r0_d = w.r0; r1_d = w.r1; r2_d = w.r2; mode_d = w.mode; vin = 1'b1;
        qa.push_back(w.ea);
        qb.push_back(w.eb);
        sent++;
      end else begin
        vin = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("random_sent", sent, 200);
    drain();
    check("random_no_error", int'(ifa.error_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
